// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Bundles the instruction-memory request/ack bus and the datapath
//   valid/ready handshake of the instruction fetch unit.
//   master : the fetch unit (drives imem_req/imem_addr and the instruction
//            outputs; receives imem_ack/imem_rdata, dp_ready and redirect info)
//   slave  : memory plus datapath side (the mirror image)
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruccion;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic        if_valid;
  logic        dp_ready;
  logic        jump;
  logic [31:0] jump_address;
  logic        branch_taken;
  logic [31:0] next_PC;
  logic        trap;

  modport master (
    output imem_req, imem_addr, instruccion, PC, PC_plus_4, if_valid, trap,
    input  imem_ack, imem_rdata, dp_ready, jump, jump_address, branch_taken, next_PC
  );

  modport slave (
    input  imem_req, imem_addr, instruccion, PC, PC_plus_4, if_valid, trap,
    output imem_ack, imem_rdata, dp_ready, jump, jump_address, branch_taken, next_PC
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   MIPS front end: owns the program counter, fetches over a req/ack memory
//   handshake, presents instruccion/PC/PC_plus_4 to the datapath with a
//   valid/ready handshake and picks the next PC from the datapath's
//   control-flow result (jump > branch_taken > sequential).
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    instr_fetch_unit_if.master (imem_*, instruccion, PC, PC_plus_4,
//          if_valid, dp_ready, jump, jump_address, branch_taken, next_PC, trap)
// Build option
//   IFU_MISALIGN_TRAP_EN : a misaligned redirect target sends the PC to
//   TRAP_VECTOR and pulses trap; without it the target's low two bits are
//   cleared and trap is tied low.
//
// state    | meaning
// ST_IDLE  | single cycle after reset release
// ST_FETCH | imem_req high at pc_q, waiting for imem_ack
// ST_HOLD  | instruction valid, waiting for dp_ready
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
`endif
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic [31:0] pc_next;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    target = pc_inc;
    if (bus.jump)              target = bus.jump_address;
    else if (bus.branch_taken) target = bus.next_PC;
  end

  // Request and address come straight from state, so an async reset drops
  // imem_req in the same instant it is asserted.
  assign bus.imem_req  = (state == ST_FETCH);
  assign bus.imem_addr = pc_q;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misaligned;

  // pc_inc is always word aligned, so only a redirect can trap.
  assign misaligned = (bus.jump | bus.branch_taken) & (target[1:0] != 2'b00);
  assign pc_next    = misaligned ? TRAP_VECTOR : target;
`else
  assign pc_next  = target & 32'hFFFF_FFFC;
  assign bus.trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      pc_q            <= RESET_PC;
      bus.instruccion <= 32'h0;
      bus.PC          <= 32'h0;
      bus.PC_plus_4   <= 32'h0;
      bus.if_valid    <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      bus.trap        <= 1'b0;
`endif
    end else begin
`ifdef IFU_MISALIGN_TRAP_EN
      bus.trap <= 1'b0;
`endif
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (bus.imem_ack) begin
            bus.instruccion <= bus.imem_rdata;
            bus.PC          <= pc_q;
            bus.PC_plus_4   <= pc_inc;
            bus.if_valid    <= 1'b1;
            state           <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.dp_ready) begin
            pc_q         <= pc_next;
            bus.if_valid <= 1'b0;
            state        <= ST_FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
            bus.trap     <= misaligned;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level reference model, a memory
// responder with random latency and stray acks, directed scenarios and a
// randomized run.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC = 32'h0000_0080;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  instr_fetch_unit_if bus ();

`ifdef IFU_MISALIGN_TRAP_EN
  instr_fetch_unit #(.RESET_PC(RST_PC), .TRAP_VECTOR(TRAP_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`else
  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // phase 0: post-reset idle, 1: request outstanding, 2: instruction held
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_pcv, m_p4;
  logic        m_valid, m_trap;

  always @(posedge clk or negedge reset) begin
    logic [31:0] t;
    logic        redir;
    if (!reset) begin
      m_phase = 0; m_pc = RST_PC; m_instr = 0; m_pcv = 0; m_p4 = 0;
      m_valid = 0; m_trap = 0;
    end else begin
      m_trap = 0;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (bus.imem_ack) begin
          m_instr = bus.imem_rdata; m_pcv = m_pc; m_p4 = m_pc + 32'd4;
          m_valid = 1; m_phase = 2;
        end
      end else if (bus.dp_ready) begin
        redir = bus.jump || bus.branch_taken;
        t = bus.jump ? bus.jump_address : (bus.branch_taken ? bus.next_PC : m_pc + 32'd4);
`ifdef IFU_MISALIGN_TRAP_EN
        if (redir && (t % 4 != 0)) begin
          m_pc = TRAP_PC; m_trap = 1;
        end else m_pc = t;
`else
        m_pc = t - (t % 4);
        if (redir) m_trap = 0;
`endif
        m_valid = 0; m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_req", 32'(bus.imem_req), 32'(m_phase == 1));
    if (m_phase == 1 || !reset) chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
    chk("instruccion", bus.instruccion, m_instr);
    chk("PC", bus.PC, m_pcv);
    chk("PC_plus_4", bus.PC_plus_4, m_p4);
    chk("trap", 32'(bus.trap), 32'(m_trap));
  end

  // ---------------- memory responder ----------------
  int          lat_min = 1, lat_max = 1, cnt = 0, lat = 1;
  bit          stray_en = 0, stray_all = 0;
  logic [31:0] log_q[$];

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bus.imem_ack = 1'b0; cnt = 0;
      end else if (bus.imem_req) begin
        cnt++;
        bus.imem_rdata = $urandom;
        if (cnt >= lat) begin
          bus.imem_ack = 1'b1;
          log_q.push_back(bus.imem_addr);
        end else bus.imem_ack = 1'b0;
      end else begin
        cnt = 0;
        lat = $urandom_range(lat_max, lat_min);
        bus.imem_rdata = $urandom;
        bus.imem_ack = stray_all || (stray_en && ($urandom_range(3, 0) == 0));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_valid();
    int n = 0;
    while (!bus.if_valid && n < 200) begin @(negedge clk); n++; end
    if (!bus.if_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid: timeout, if_valid got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (log_q.size() < n && k < 200) begin @(negedge clk); k++; end
    if (log_q.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_log: timeout, fetches got %0d expected %0d", log_q.size(), n);
    end
  endtask

  task automatic consume();
    bus.dp_ready = 1'b1;
    @(negedge clk);
    bus.dp_ready = 1'b0;
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bus.dp_ready = 0; bus.jump = 0; bus.branch_taken = 0;
    bus.jump_address = 0; bus.next_PC = 0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_PC", bus.PC, 32'h0);
    chk("rst_PC_plus_4", bus.PC_plus_4, 32'h0);
    chk("rst_instruccion", bus.instruccion, 32'h0);
    #2 reset = 1'b1;

    // sequential fetch, 1-cycle memory, datapath always ready
    bus.dp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      chk("seq_PC", bus.PC, 32'(4 * i));
      chk("seq_PC_plus_4", bus.PC_plus_4, 32'(4 * i + 4));
      @(negedge clk);
      chk("seq_valid_pulse", 32'(bus.if_valid), 32'h0);
    end
    bus.dp_ready = 1'b0;
    chk("seq_addr0", log_at(0), 32'h0);
    chk("seq_addr1", log_at(1), 32'h4);
    chk("seq_addr2", log_at(2), 32'h8);

    // datapath stall for five cycles
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      chk("stall_req", 32'(bus.imem_req), 32'h0);
      chk("stall_valid", 32'(bus.if_valid), 32'h1);
    end
    base = log_q.size();
    consume();
    wait_log(base + 1);
    chk("stall_next", log_at(base), m_pcv + 32'd4);

    // jump beats branch
    wait_valid();
    bus.jump = 1; bus.jump_address = 32'h0040_0100;
    bus.branch_taken = 1; bus.next_PC = 32'h0000_0200;
    base = log_q.size();
    consume();
    wait_log(base + 1);
    chk("jump_prio", log_at(base), 32'h0040_0100);

    // branch taken
    wait_valid();
    bus.branch_taken = 1; bus.next_PC = 32'h0000_0040;
    base = log_q.size();
    consume();
    wait_log(base + 1);
    chk("branch", log_at(base), 32'h0000_0040);

    // redirect presented without dp_ready is ignored
    wait_valid();
    bus.jump = 1; bus.jump_address = 32'h0000_0500;
    bus.branch_taken = 1; bus.next_PC = 32'h0000_0300;
    repeat (3) @(negedge clk);
    bus.jump = 0; bus.branch_taken = 0;
    base = log_q.size();
    consume();
    wait_log(base + 1);
    chk("redir_ignored", log_at(base), 32'h0000_0044);

    // PC wrap
    wait_valid();
    bus.jump = 1; bus.jump_address = 32'hFFFF_FFFC;
    consume();
    wait_valid();
    chk("wrap_PC", bus.PC, 32'hFFFF_FFFC);
    chk("wrap_PC_plus_4", bus.PC_plus_4, 32'h0);
    base = log_q.size();
    consume();
    wait_log(base + 1);
    chk("wrap_next", log_at(base), 32'h0);

`ifdef IFU_MISALIGN_TRAP_EN
    wait_valid();
    bus.jump = 1; bus.jump_address = 32'h0000_0102;
    consume();
    chk("trap_pulse", 32'(bus.trap), 32'h1);
    chk("trap_addr", bus.imem_addr, TRAP_PC);
    @(negedge clk);
    chk("trap_clear", 32'(bus.trap), 32'h0);
`endif

    // reset during an outstanding fetch, stray ack while idle
    lat_min = 6; lat_max = 6;
    wait_valid();
    consume();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_mid_req", 32'(bus.imem_req), 32'h0);
    chk("rst_mid_addr", bus.imem_addr, RST_PC);
    stray_all = 1;
    repeat (3) @(negedge clk);
    base = log_q.size();
    #2 reset = 1'b1;
    @(negedge clk);
    stray_all = 0;
    lat_min = 1; lat_max = 3;
    wait_log(base + 1);
    chk("post_rst_fetch", log_at(base), RST_PC);

    // randomized run
    lat_min = 1; lat_max = 4; stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.dp_ready = ($urandom_range(1, 0) == 1);
      bus.jump = ($urandom_range(3, 0) == 0);
      bus.branch_taken = ($urandom_range(2, 0) == 0);
      bus.jump_address = $urandom & (($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      bus.next_PC = $urandom & (($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
    end
    bus.dp_ready = 0; bus.jump = 0; bus.branch_taken = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
